// File: rtl/instr_ram_loader.sv
// Boot-time byte-stream loader and asynchronous-read instruction RAM.
// Holds the CPU in reset until a complete image has been written.
module instr_ram_loader #(
   parameter int SIZE   = 1024,
   parameter int ADDR_W = $clog2(SIZE)
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              in_valid,
   input  logic [7:0]        in_data,
   output logic              in_ready,
   input  logic              reload,
   input  logic [ADDR_W-1:0] a,
   output logic [31:0]       rd,
   output logic              cpu_rst,
   output logic [ADDR_W:0]   loaded_words,
   output logic              error
);

   typedef enum logic [2:0] {
      IDLE, HDR0, HDR1, DATA, RUN, ERR
   } state_t;

   state_t state, nextState;

   logic [31:0]       mem [SIZE];
   logic [15:0]       hdr;
   logic [1:0]        byteIdx;
   logic [23:0]       shiftReg;
   logic [ADDR_W-1:0] waddr;
   logic [ADDR_W:0]   wordCnt;

   logic        take;
   logic        wordDone;
   logic        lastWord;
   logic        hdrBad;
   logic        restart;
   logic [15:0] nFull;
   logic [31:0] wordData;

   assign take     = in_valid & in_ready;
   assign nFull    = {in_data, hdr[7:0]};
   assign hdrBad   = (nFull == 16'd0) || (17'(nFull) > 17'(SIZE));
   assign wordDone = take && (state == DATA) && (byteIdx == 2'd3);
   assign wordData = {in_data, shiftReg};
   assign lastWord = wordDone && ((17'(wordCnt) + 17'd1) == 17'(hdr));
   assign restart  = reload && ((state == RUN) || (state == ERR));

   // Status outputs decode only registered state
   assign in_ready     = (state == HDR0) || (state == HDR1) || (state == DATA);
   assign cpu_rst      = (state != RUN);
   assign error        = (state == ERR);
   assign loaded_words = wordCnt;
   assign rd           = mem[a];

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) state <= IDLE;
      else      state <= nextState;
   end

   always_comb begin
      nextState = state;
      unique case (state)
         IDLE:     nextState = HDR0;
         HDR0:     if (take) nextState = HDR1;
         HDR1:     if (take) nextState = hdrBad ? ERR : DATA;
         DATA:     if (lastWord) nextState = RUN;
         RUN, ERR: if (reload) nextState = HDR0;
         default:  nextState = IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         hdr      <= '0;
         byteIdx  <= '0;
         shiftReg <= '0;
         waddr    <= '0;
         wordCnt  <= '0;
      end else if (restart) begin
         byteIdx <= '0;
         waddr   <= '0;
         wordCnt <= '0;
      end else if (take) begin
         unique case (state)
            HDR0: hdr[7:0] <= in_data;
            HDR1: begin
               hdr[15:8] <= in_data;
               byteIdx   <= '0;
               waddr     <= '0;
               wordCnt   <= '0;
            end
            DATA: begin
               byteIdx  <= byteIdx + 2'd1;
               shiftReg <= {in_data, shiftReg[23:8]};
               if (byteIdx == 2'd3) begin
                  waddr   <= waddr + 1'b1;
                  wordCnt <= wordCnt + 1'b1;
               end
            end
            default: ;
         endcase
      end
   end

   // RAM is deliberately never cleared
   always_ff @(posedge clk) begin
      if (wordDone) mem[waddr] <= wordData;
   end

endmodule

// File: tb/tb_instr_ram_loader.sv
// Randomized self-checking bench for instr_ram_loader.
// Reference model parses the byte stream and tracks expected RAM contents.
module tb_instr_ram_loader;

   localparam int SIZE = 1024;
   localparam int AW   = 10;

   logic          clk;
   logic          rst;
   logic          in_valid;
   logic [7:0]    in_data;
   logic          in_ready;
   logic          reload;
   logic [AW-1:0] a;
   logic [31:0]   rd;
   logic          cpu_rst;
   logic [AW:0]   loaded_words;
   logic          error;

   int checks;
   int failures;
   bit sendTimeout;

   logic [7:0]  img [$];
   logic [31:0] refMem [SIZE];
   bit          written [SIZE];

   instr_ram_loader #(.SIZE(SIZE)) dut (
      .clk(clk),
      .rst(rst),
      .in_valid(in_valid),
      .in_data(in_data),
      .in_ready(in_ready),
      .reload(reload),
      .a(a),
      .rd(rd),
      .cpu_rst(cpu_rst),
      .loaded_words(loaded_words),
      .error(error)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic buildImage(input int n, input logic [31:0] first,
                             input bit useFirst);
      logic [31:0] w;
      img.delete();
      img.push_back(8'(n));
      img.push_back(8'(n >> 8));
      for (int i = 0; i < n; i++) begin
         w = (i == 0 && useFirst) ? first : $urandom;
         for (int k = 0; k < 4; k++) img.push_back(8'(w >> (8 * k)));
      end
   endtask

   task automatic sendByte(input logic [7:0] b, input int gmin,
                           input int gmax);
      int g;
      int t;
      g = (gmax > 0) ? $urandom_range(gmax, gmin) : 0;
      repeat (g) begin
         in_valid = 1'b0;
         in_data  = 8'($urandom);
         @(negedge clk);
      end
      in_valid = 1'b1;
      in_data  = b;
      t = 0;
      while (!in_ready && t < 20) begin
         @(negedge clk);
         t++;
      end
      checks++;
      if (!in_ready) begin
         failures++;
         sendTimeout = 1'b1;
         $display("FAIL accept_timeout in_ready=%b required=1", in_ready);
         in_valid = 1'b0;
      end else begin
         @(negedge clk);
         in_valid = 1'b0;
      end
   endtask

   task automatic reloadPulse();
      @(negedge clk);
      reload = 1'b1;
      @(negedge clk);
      reload = 1'b0;
      checks++;
      if ({in_ready, cpu_rst, error} !== 3'b110 || loaded_words !== '0) begin
         failures++;
         $display("FAIL reload rdy/cpurst/err=%b lw=%0d required 110 lw=0",
                  {in_ready, cpu_rst, error}, loaded_words);
      end
   endtask

   // Sends img and compares DUT behaviour against the stream's meaning.
   task automatic loadImage(input int gmin, input int gmax,
                            input int reloadAfter);
      int  n;
      bit  bad;
      int  last;
      int  k;
      int  w;
      n    = {img[1], img[0]};
      bad  = (n == 0) || (n > SIZE);
      last = img.size() - 1;
      for (int i = 0; i <= last; i++) begin
         sendByte(img[i], gmin, gmax);
         if (sendTimeout) return;
         if (i == 1 && bad) begin
            checks++;
            if ({error, in_ready, cpu_rst} !== 3'b101) begin
               failures++;
               $display("FAIL hdr_reject err/rdy/cpurst=%b required 101",
                        {error, in_ready, cpu_rst});
            end
            return;
         end
         if (i >= 2) begin
            k = i - 2;
            if (k % 4 == 3) begin
               w = k / 4;
               refMem[w]  = {img[i], img[i-1], img[i-2], img[i-3]};
               written[w] = 1'b1;
               checks++;
               if (loaded_words !== (AW+1)'(w + 1)) begin
                  failures++;
                  $display("FAIL word_count lw=%0d required %0d",
                           loaded_words, w + 1);
               end
               a = AW'(w);
               #1;
               checks++;
               if (rd !== refMem[w]) begin
                  failures++;
                  $display("FAIL word_visible addr=%0d rd=%h required %h",
                           w, rd, refMem[w]);
               end
            end
         end
         checks++;
         if (cpu_rst !== (i != last)) begin
            failures++;
            $display("FAIL cpu_rst_timing byte=%0d cpu_rst=%b required %b",
                     i, cpu_rst, i != last);
         end
         if (i == reloadAfter) begin
            @(negedge clk);
            reload = 1'b1;
            @(negedge clk);
            reload = 1'b0;
            checks++;
            if ({in_ready, cpu_rst, error} !== 3'b110 ||
                loaded_words !== (AW+1)'((i - 1) / 4)) begin
               failures++;
               $display("FAIL reload_in_data rdy/cpurst/err=%b lw=%0d required 110 lw=%0d",
                        {in_ready, cpu_rst, error}, loaded_words, (i - 1) / 4);
            end
         end
      end
      checks++;
      if (loaded_words !== (AW+1)'(n) || {cpu_rst, in_ready, error} !== 3'b000) begin
         failures++;
         $display("FAIL load_done lw=%0d cpurst/rdy/err=%b required lw=%0d 000",
                  loaded_words, {cpu_rst, in_ready, error}, n);
      end
      for (int j = 0; j < SIZE; j++) begin
         if (written[j]) begin
            a = AW'(j);
            #1;
            checks++;
            if (rd !== refMem[j]) begin
               failures++;
               $display("FAIL readback addr=%0d rd=%h required %h",
                        j, rd, refMem[j]);
            end
         end
      end
   endtask

   task automatic test_reset();
      rst = 1'b0;
      repeat (3) @(negedge clk);
      checks++;
      if ({in_ready, cpu_rst, error} !== 3'b010 || loaded_words !== '0) begin
         failures++;
         $display("FAIL reset_state rdy/cpurst/err=%b lw=%0d required 010 lw=0",
                  {in_ready, cpu_rst, error}, loaded_words);
      end
      rst = 1'b1;
      #1;
      checks++;
      if (in_ready !== 1'b0) begin
         failures++;
         $display("FAIL idle_cycle in_ready=%b required 0", in_ready);
      end
      @(negedge clk);
      checks++;
      if (in_ready !== 1'b1) begin
         failures++;
         $display("FAIL ready_after_idle in_ready=%b required 1", in_ready);
      end
   endtask

   task automatic test_load_n2();
      img = {8'h02, 8'h00, 8'h13, 8'h05, 8'h50, 8'h00,
             8'h13, 8'h00, 8'h00, 8'h00};
      loadImage(0, 0, -1);
      a = 0;
      #1;
      checks++;
      if (rd !== 32'h0050_0513) begin
         failures++;
         $display("FAIL n2_word0 rd=%h required 00500513", rd);
      end
      a = 1;
      #1;
      checks++;
      if (rd !== 32'h0000_0013) begin
         failures++;
         $display("FAIL n2_word1 rd=%h required 00000013", rd);
      end
   endtask

   task automatic test_gaps();
      reloadPulse();
      img = {8'h02, 8'h00, 8'h13, 8'h05, 8'h50, 8'h00,
             8'h13, 8'h00, 8'h00, 8'h00};
      loadImage(1, 5, -1);
      a = 1;
      #1;
      checks++;
      if (rd !== 32'h0000_0013 || loaded_words !== 11'd2) begin
         failures++;
         $display("FAIL gaps_result rd=%h lw=%0d required 00000013 lw=2",
                  rd, loaded_words);
      end
   endtask

   task automatic test_zero_header();
      reloadPulse();
      img = {8'h00, 8'h00};
      loadImage(0, 0, -1);
      repeat (4) begin
         in_valid = 1'b1;
         in_data  = 8'($urandom);
         @(negedge clk);
      end
      in_valid = 1'b0;
      checks++;
      if ({error, in_ready, cpu_rst} !== 3'b101 || loaded_words !== '0) begin
         failures++;
         $display("FAIL err_hold err/rdy/cpurst=%b lw=%0d required 101 lw=0",
                  {error, in_ready, cpu_rst}, loaded_words);
      end
      reloadPulse();
      buildImage(1, 32'h0, 1'b0);
      loadImage(0, 3, -1);
   endtask

   task automatic test_size_limits();
      reloadPulse();
      img = {8'h01, 8'h04};
      loadImage(0, 0, -1);
      reloadPulse();
      buildImage(1024, 32'h0, 1'b0);
      loadImage(0, 0, -1);
      a = AW'(1023);
      #1;
      checks++;
      if (rd !== {img[4097], img[4096], img[4095], img[4094]}) begin
         failures++;
         $display("FAIL last_addr rd=%h required %h", rd,
                  {img[4097], img[4096], img[4095], img[4094]});
      end
   endtask

   task automatic test_reset_mid_load();
      reloadPulse();
      buildImage(2, 32'h0, 1'b0);
      for (int i = 0; i < 5; i++) sendByte(img[i], 0, 0);
      #2;
      rst = 1'b0;
      #1;
      checks++;
      if ({cpu_rst, in_ready, error} !== 3'b100 || loaded_words !== '0) begin
         failures++;
         $display("FAIL mid_reset cpurst/rdy/err=%b lw=%0d required 100 lw=0",
                  {cpu_rst, in_ready, error}, loaded_words);
      end
      a = 0;
      #1;
      checks++;
      if (rd !== refMem[0]) begin
         failures++;
         $display("FAIL partial_discard rd=%h required %h", rd, refMem[0]);
      end
      @(negedge clk);
      rst = 1'b1;
      #1;
      checks++;
      if (in_ready !== 1'b0) begin
         failures++;
         $display("FAIL idle_after_mid_reset in_ready=%b required 0", in_ready);
      end
      @(negedge clk);
      buildImage(1, 32'h0, 1'b0);
      loadImage(0, 0, -1);
   endtask

   task automatic test_reload_run();
      reloadPulse();
      buildImage(3, 32'h0, 1'b0);
      loadImage(0, 2, -1);
      reloadPulse();
      buildImage(1, 32'hDEAD_BEEF, 1'b1);
      loadImage(0, 0, 3);
      a = 0;
      #1;
      checks++;
      if (rd !== 32'hDEAD_BEEF) begin
         failures++;
         $display("FAIL reload_word rd=%h required deadbeef", rd);
      end
   endtask

   initial begin
      checks      = 0;
      failures    = 0;
      sendTimeout = 1'b0;
      in_valid    = 1'b0;
      in_data     = '0;
      reload      = 1'b0;
      a           = '0;
      rst         = 1'b0;
      for (int i = 0; i < SIZE; i++) written[i] = 1'b0;
      test_reset();
      test_load_n2();
      test_gaps();
      test_zero_header();
      test_size_limits();
      test_reset_mid_load();
      test_reload_run();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
